// File: rtl/pll_reconfig_seq_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
// Holds the reconfig block register map and the sequencer state encoding.
package pll_reconfig_pkg;

  localparam logic [5:0] REG_MODE   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_START  = 6'h02;
  localparam logic [5:0] REG_N      = 6'h03;
  localparam logic [5:0] REG_M      = 6'h04;
  localparam logic [5:0] REG_C      = 6'h05;
  localparam logic [5:0] REG_DPS    = 6'h06;
  localparam logic [5:0] REG_M_FRAC = 6'h07;
  localparam logic [5:0] REG_BW     = 6'h08;
  localparam logic [5:0] REG_CP     = 6'h09;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MODE,
    S_CMD,
    S_CMD_WR,
    S_START,
    S_WAIT_LOCK,
    S_PRST,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management port of the PLL reconfiguration block (write-only).
//   master: drives mgmt_address / mgmt_write / mgmt_writedata, samples mgmt_waitrequest
//   slave : the reconfig block side
interface pll_reconfig_seq_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_reconfig_seq_lock_filter.sv
// PLL lock filter: synchronizes the asynchronous locked flag into refclk and
// accepts lock only after LOCK_STABLE consecutive high samples.
//   refclk, rst : clock and asynchronous active-high reset
//   clr         : restart the stability count (new reconfiguration started)
//   pll_locked  : raw lock flag from the PLL
//   lock_ok     : lock held stable for LOCK_STABLE cycles
module pll_lock_filter #(
  parameter int unsigned LOCK_STABLE = 1024
) (
  input  logic refclk,
  input  logic rst,
  input  logic clr,
  input  logic pll_locked,
  output logic lock_ok
);

  localparam int unsigned W = $clog2(LOCK_STABLE + 1);

  logic [1:0]   sync_q;
  logic [W-1:0] cnt_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      if (clr || !sync_q[1])
        cnt_q <= '0;
      else if (cnt_q != W'(LOCK_STABLE))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lock_ok = (cnt_q == W'(LOCK_STABLE));

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer. On cfg_req it puts the reconfig block in
// waitrequest mode, streams the requested register writes, starts the
// update and waits for a stable lock, retrying once through a PLL reset.
//   refclk, rst        : management clock, asynchronous active-high reset
//   cfg_req            : start pulse, honoured only when idle
//   cmd_*              : command stream (valid/ready, addr, data, last)
//   mgmt               : Avalon-MM master to the reconfig block
//   pll_locked         : asynchronous PLL lock flag
//   pll_rst            : registered PLL reset pulse (retry only)
//   busy, done, error  : sequence status
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 2_000_000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned MAX_WRITES   = 32
) (
  input  logic                       refclk,
  input  logic                       rst,
  input  logic                       cfg_req,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [5:0]                 cmd_addr,
  input  logic [31:0]                cmd_data,
  input  logic                       cmd_last,
  pll_reconfig_seq_if.master         mgmt,
  input  logic                       pll_locked,
  output logic                       pll_rst,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned CW = $clog2(MAX_WRITES + 1);
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  state_t        state_q, state_d;
  logic [5:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic          prst_q, prst_d, retry_q, retry_d, last_q, last_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          filt_clr, lock_ok, wr_done;

  pll_lock_filter #(.LOCK_STABLE(LOCK_STABLE)) u_lock_filter (
    .refclk     (refclk),
    .rst        (rst),
    .clr        (filt_clr),
    .pll_locked (pll_locked),
    .lock_ok    (lock_ok)
  );

  assign wr_done   = wr_q & ~mgmt.mgmt_waitrequest;
  assign cmd_ready = (state_q == S_CMD) & ~wr_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    prst_d    = 1'b0;
    retry_d   = retry_q;
    last_d    = last_q;
    wr_cnt_d  = wr_cnt_q;
    timer_d   = timer_q;
    rst_cnt_d = rst_cnt_q;
    filt_clr  = 1'b0;
    case (state_q)
      S_IDLE: if (cfg_req) begin
        state_d  = S_MODE;
        busy_d   = 1'b1;
        error_d  = 1'b0;
        wr_cnt_d = '0;
        retry_d  = 1'b0;
        addr_d   = REG_MODE;
        data_d   = '0;
        wr_d     = 1'b1;
      end
      S_MODE: if (wr_done) begin
        wr_d    = 1'b0;
        state_d = S_CMD;
      end
      S_CMD: if (cmd_valid && cmd_ready) begin
        addr_d  = cmd_addr;
        data_d  = cmd_data;
        last_d  = cmd_last;
        wr_d    = 1'b1;
        state_d = S_CMD_WR;
      end
      S_CMD_WR: if (wr_done) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (last_q) begin
          // START write is issued straight from the last command completion
          state_d = S_START;
          addr_d  = REG_START;
          data_d  = 32'd1;
        end else if (wr_cnt_d == CW'(MAX_WRITES)) begin
          state_d = S_ERR;
          wr_d    = 1'b0;
        end else begin
          state_d = S_CMD;
          wr_d    = 1'b0;
        end
      end
      S_START: if (wr_done) begin
        wr_d     = 1'b0;
        timer_d  = '0;
        filt_clr = 1'b1;
        state_d  = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // lock is checked first so it wins over a coincident timeout
        if (lock_ok) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (timer_q == TW'(LOCK_TIMEOUT)) begin
          if (!retry_q) begin
            state_d   = S_PRST;
            prst_d    = 1'b1;
            rst_cnt_d = '0;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PRST: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
          retry_d = 1'b1;
        end else begin
          prst_d = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      prst_q    <= 1'b0;
      retry_q   <= 1'b0;
      last_q    <= 1'b0;
      wr_cnt_q  <= '0;
      timer_q   <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      prst_q    <= prst_d;
      retry_q   <= retry_d;
      last_q    <= last_d;
      wr_cnt_q  <= wr_cnt_d;
      timer_q   <= timer_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign mgmt.mgmt_address   = addr_q;
  assign mgmt.mgmt_write     = wr_q;
  assign mgmt.mgmt_writedata = data_q;
  assign pll_rst = prst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
module tb_pll_reconfig_seq;

  localparam int LT    = 3000;
  localparam int LS    = 1024;
  localparam int RC    = 64;
  localparam int MW    = 32;
  localparam int WAITS = 2;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_req = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_last = 1'b0;
  logic        pll_locked = 1'b0;
  logic        pll_rst, busy, done, error;

  pll_reconfig_seq_if bus();

  pll_reconfig_seq #(
    .LOCK_TIMEOUT (LT),
    .LOCK_STABLE  (LS),
    .RST_CYCLES   (RC),
    .MAX_WRITES   (MW)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .cfg_req    (cfg_req),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_last   (cmd_last),
    .mgmt       (bus),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 refclk = ~refclk;

  int          n_vec = 0;
  int          n_err = 0;
  int          ws = 0;
  bit          hold_wait = 1'b0;
  bit          start_seen = 1'b0;
  int          done_cnt = 0;
  logic [37:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Avalon slave: WAITS stall cycles per write, or stall forever while hold_wait
  assign bus.mgmt_waitrequest = bus.mgmt_write & (hold_wait | (ws <= WAITS));

  always @(negedge refclk) begin
    logic [37:0] e;
    if (done) done_cnt++;
    if (!bus.mgmt_write) ws = 0;
    else if (!hold_wait) begin
      if (ws == WAITS + 1) ws = 1;
      else ws = ws + 1;
      if (ws == WAITS + 1) begin
        if (exp_q.size() == 0)
          check("wr_unexpected", {26'b0, bus.mgmt_address}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", {26'b0, bus.mgmt_address}, {26'b0, e[37:32]});
          check("wr_data", bus.mgmt_writedata, e[31:0]);
        end
        if (bus.mgmt_address == 6'h02) start_seen = 1'b1;
      end
    end
  end

  function automatic bit sig(input int which);
    case (which)
      0:       return done;
      1:       return pll_rst;
      2:       return busy;
      default: return bus.mgmt_write;
    endcase
  endfunction

  task automatic wait_level(input int which, input bit level, input int max, output int n);
    n = 0;
    do begin
      @(posedge refclk); #1;
      n++;
    end while (sig(which) != level && n < max);
  endtask

  task automatic request();
    start_seen = 1'b0;
    exp_q.push_back({6'h00, 32'h0});
    @(posedge refclk); #1 cfg_req = 1'b1;
    @(posedge refclk); #1 cfg_req = 1'b0;
  endtask

  task automatic send_cmd(input logic [5:0] a, input logic [31:0] d, input bit last,
                          input bit push, output bit ok);
    if (push) exp_q.push_back({a, d});
    cmd_addr = a; cmd_data = d; cmd_last = last; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge refclk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge refclk);
    #1 cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  // returns on the refclk edge that completes the START write
  task automatic wait_start();
    for (int n = 0; n < 2000; n++) begin
      @(posedge refclk);
      if (start_seen) break;
    end
    check("start_write", {31'b0, start_seen}, 32'd1);
  endtask

  initial begin
    bit ok;
    int n, acc, dc;

    // reset state
    repeat (3) @(posedge refclk);
    #1;
    check("rst_mgmt_write", {31'b0, bus.mgmt_write}, 32'd0);
    check("rst_mgmt_addr", {26'b0, bus.mgmt_address}, 32'd0);
    check("rst_mgmt_data", bus.mgmt_writedata, 32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_pll_rst", {31'b0, pll_rst}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    rst = 1'b0;

    // 1: three commands, lock 100 cycles after START
    request();
    check("t1_busy", {31'b0, busy}, 32'd1);
    send_cmd(6'h04, 32'h0000_0808, 1'b0, 1'b1, ok);
    send_cmd(6'h03, 32'h0001_0000, 1'b0, 1'b1, ok);
    send_cmd(6'h05, 32'h0000_0202, 1'b1, 1'b1, ok);
    exp_q.push_back({6'h02, 32'h1});
    wait_start();
    repeat (100) @(posedge refclk);
    #1 pll_locked = 1'b1;
    @(posedge refclk);
    wait_level(0, 1'b1, LS + 200, n);
    check("t1_lock_latency", n, LS + 2);
    @(posedge refclk); #1;
    check("t1_done_pulse", {31'b0, done}, 32'd0);
    check("t1_busy_end", {31'b0, busy}, 32'd0);
    check("t1_error", {31'b0, error}, 32'd0);
    check("t1_sb_empty", exp_q.size(), 32'd0);

    // 2: lock never comes back
    pll_locked = 1'b0;
    dc = done_cnt;
    request();
    send_cmd(6'h08, 32'h0000_0003, 1'b1, 1'b1, ok);
    exp_q.push_back({6'h02, 32'h1});
    wait_start();
    wait_level(1, 1'b1, LT + 100, n);
    check("t2_prst_delay", n, LT + 1);
    wait_level(1, 1'b0, RC + 10, n);
    check("t2_prst_width", n, RC);
    wait_level(2, 1'b0, LT + 100, n);
    check("t2_busy", {31'b0, busy}, 32'd0);
    check("t2_error", {31'b0, error}, 32'd1);
    check("t2_no_done", done_cnt - dc, 32'd0);

    // 3: lock arrives during the retry
    dc = done_cnt;
    request();
    check("t3_error_cleared", {31'b0, error}, 32'd0);
    send_cmd(6'h04, 32'h0000_0505, 1'b1, 1'b1, ok);
    exp_q.push_back({6'h02, 32'h1});
    wait_start();
    wait_level(1, 1'b1, LT + 100, n);
    check("t3_prst", {31'b0, pll_rst}, 32'd1);
    wait_level(1, 1'b0, RC + 10, n);
    repeat (50) @(posedge refclk);
    #1 pll_locked = 1'b1;
    wait_level(2, 1'b0, LT, n);
    check("t3_done", done_cnt - dc, 32'd1);
    check("t3_error", {31'b0, error}, 32'd0);

    // 4: MAX_WRITES+1 commands without cmd_last
    request();
    acc = 0;
    for (int i = 0; i < MW; i++) begin
      send_cmd(6'h05, 32'(i), 1'b0, 1'b1, ok);
      acc += int'(ok);
    end
    check("t4_accepted", acc, MW);
    send_cmd(6'h05, 32'hDEAD, 1'b0, 1'b0, ok);
    check("t4_extra_rejected", {31'b0, ok}, 32'd0);
    check("t4_error", {31'b0, error}, 32'd1);
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_no_start", {31'b0, start_seen}, 32'd0);
    check("t4_sb_empty", exp_q.size(), 32'd0);

    // 5: async reset while a write is stalled
    hold_wait = 1'b1;
    request();
    check("t5_write_held", {31'b0, bus.mgmt_write}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_write", {31'b0, bus.mgmt_write}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_error", {31'b0, error}, 32'd0);
    check("t5_rst_addr", {26'b0, bus.mgmt_address}, 32'd0);
    exp_q.delete();
    hold_wait = 1'b0;
    @(posedge refclk); #1 rst = 1'b0;
    dc = done_cnt;
    request();
    send_cmd(6'h09, 32'h0000_0002, 1'b1, 1'b1, ok);
    exp_q.push_back({6'h02, 32'h1});
    wait_start();
    wait_level(2, 1'b0, LT, n);
    check("t5_done", done_cnt - dc, 32'd1);
    check("t5_error", {31'b0, error}, 32'd0);

    // 6: one-cycle lock glitch at count 1000, cfg_req while busy and in DONE
    pll_locked = 1'b0;
    dc = done_cnt;
    request();
    send_cmd(6'h09, 32'h0000_0004, 1'b1, 1'b1, ok);
    exp_q.push_back({6'h02, 32'h1});
    wait_start();
    @(posedge refclk); #1 cfg_req = 1'b1;
    @(posedge refclk); #1 cfg_req = 1'b0;
    repeat (98) @(posedge refclk);
    #1 pll_locked = 1'b1;
    @(posedge refclk);
    repeat (1001) @(posedge refclk);
    #1 pll_locked = 1'b0;
    @(posedge refclk);
    #1 pll_locked = 1'b1;
    check("t6_no_early_done", done_cnt - dc, 32'd0);
    @(posedge refclk);
    wait_level(0, 1'b1, LS + 200, n);
    check("t6_glitch_latency", n, LS + 2);
    cfg_req = 1'b1;
    @(posedge refclk); #1 cfg_req = 1'b0;
    check("t6_req_in_done", {31'b0, busy}, 32'd0);
    repeat (4) @(posedge refclk);
    #1;
    check("t6_idle", {31'b0, busy}, 32'd0);
    check("t6_one_done", done_cnt - dc, 32'd1);
    check("t6_sb_empty", exp_q.size(), 32'd0);

    // 7: exactly MAX_WRITES commands, last flagged on the final one
    dc = done_cnt;
    request();
    for (int i = 0; i < MW; i++)
      send_cmd(6'h07, 32'h100 + 32'(i), (i == MW - 1), 1'b1, ok);
    exp_q.push_back({6'h02, 32'h1});
    wait_start();
    wait_level(2, 1'b0, LT, n);
    check("t7_done", done_cnt - dc, 32'd1);
    check("t7_error", {31'b0, error}, 32'd0);
    check("t7_sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
